// File: rtl/regfile_dump.sv
// Sequential debug reader: walks FIRST_REG..LAST_REG over the register file A port and streams values on valid/ready.
// Optional trailing XOR checksum beat (DumpAddr=31) when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 30
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        Start,
  output logic [4:0]  RA,
  input  logic [63:0] BusA,
  output logic [63:0] DumpData,
  output logic [4:0]  DumpAddr,
  output logic        DumpValid,
  input  logic        DumpReady,
  output logic        DumpLast,
  output logic        Busy,
  output logic        Done
);

  localparam logic [4:0] LP_FIRST = FIRST_REG[4:0];
  localparam logic [4:0] LP_LAST  = LAST_REG[4:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
`ifdef REGDUMP_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_ra;
  logic [63:0] r_data;
  logic [4:0]  r_addr;
  logic        r_valid;
  logic        r_last;
  logic        w_hs;
  logic        w_at_last;
`ifdef REGDUMP_CHECKSUM_EN
  logic [63:0] r_acc;
`endif

  assign w_hs      = r_valid & DumpReady;
  assign w_at_last = (r_ra == LP_LAST);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (Start) w_state_nxt = S_READ;
      S_READ: w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_hs) begin
          if (w_at_last) begin
`ifdef REGDUMP_CHECKSUM_EN
            w_state_nxt = S_CSUM;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_state_nxt = S_READ;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_CSUM: if (w_hs) w_state_nxt = S_DONE;
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_ra    <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      r_acc   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_ra <= LP_FIRST;
`ifdef REGDUMP_CHECKSUM_EN
            r_acc <= '0;
`endif
          end
        end
        S_READ: begin
          r_data  <= BusA;
          r_addr  <= r_ra;
          r_valid <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          r_last  <= 1'b0;
`else
          r_last  <= w_at_last;
`endif
        end
        S_SEND: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            if (!w_at_last) r_ra <= r_ra + 5'd1;
`ifdef REGDUMP_CHECKSUM_EN
            r_acc <= r_acc ^ r_data;
            // Checksum beat is presented straight off the last handshake, costing one cycle
            if (w_at_last) begin
              r_data  <= r_acc ^ r_data;
              r_addr  <= 5'd31;
              r_last  <= 1'b1;
              r_valid <= 1'b1;
            end
`endif
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        S_CSUM: if (w_hs) r_valid <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

  assign RA        = r_ra;
  assign DumpData  = r_data;
  assign DumpAddr  = r_addr;
  assign DumpValid = r_valid;
  assign DumpLast  = r_last;
  assign Busy      = (r_state != S_IDLE);
  assign Done      = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table of dump scenarios plus hand-written reset/restart sequences.
module tb_regfile_dump;

  logic        Clk = 1'b0;
  logic        ResetN;
  logic        Start;
  logic [4:0]  RA;
  logic [63:0] BusA;
  logic [63:0] DumpData;
  logic [4:0]  DumpAddr;
  logic        DumpValid;
  logic        DumpReady;
  logic        DumpLast;
  logic        Busy;
  logic        Done;

  logic [63:0] mem [32];
  int n_cmp = 0;
  int n_err = 0;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int NB = 32;
`else
  localparam int NB = 31;
`endif

  always #5 Clk = ~Clk;
  assign BusA = mem[RA];

  regfile_dump #(.FIRST_REG(0), .LAST_REG(30)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .RA(RA), .BusA(BusA),
    .DumpData(DumpData), .DumpAddr(DumpAddr), .DumpValid(DumpValid),
    .DumpReady(DumpReady), .DumpLast(DumpLast), .Busy(Busy), .Done(Done)
  );

  typedef struct {
    logic [63:0] base;
    bit          x0_one;
    int          stalls;
    bit          rnd;
    int          start_beat;
    bit          hold_start;
    int          exp_cycles;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_RA"},        64'(RA),        64'd0);
    chk({tag, "_DumpData"},  DumpData,       64'd0);
    chk({tag, "_DumpAddr"},  64'(DumpAddr),  64'd0);
    chk({tag, "_DumpValid"}, 64'(DumpValid), 64'd0);
    chk({tag, "_DumpLast"},  64'(DumpLast),  64'd0);
    chk({tag, "_Busy"},      64'(Busy),      64'd0);
    chk({tag, "_Done"},      64'(Done),      64'd0);
  endtask

  // Called #1 after a posedge; asserts reset mid-cycle and releases it away from an edge
  task automatic do_reset(input string tag);
    #2 ResetN = 1'b0;
    #1 chk_reset_outputs(tag);
    Start = 1'b0;
    DumpReady = 1'b0;
    @(posedge Clk); #1;
    ResetN = 1'b1;
  endtask

  task automatic preload(input logic [63:0] base, input bit x0_one);
    for (int i = 0; i < 32; i++) mem[i] = base + 64'(i);
    if (x0_one) mem[0] = 64'd1;
  endtask

  task automatic run_dump(input vec_t v);
    int cyc, beat, left, nstall, exp_c;
    logic [63:0] csum, h_data, e_data;
    logic [4:0]  h_addr, e_addr;
    logic        h_last, e_last, held;
    csum = '0; held = 1'b0; h_data = '0; h_addr = '0; h_last = 1'b0;
    Start = 1'b1;
    DumpReady = 1'b0;
    @(posedge Clk); #1;
    if (!v.hold_start) Start = 1'b0;
    chk("busy_after_start", 64'(Busy), 64'd1);
    chk("ra_first", 64'(RA), 64'd0);
    cyc = 0; beat = 0; nstall = 0; left = v.stalls;
    while (!Done && cyc < 600) begin
      DumpReady = 1'b0;
      if (held) begin
        chk("hold_valid", 64'(DumpValid), 64'd1);
        chk("hold_data",  DumpData,       h_data);
        chk("hold_addr",  64'(DumpAddr),  64'(h_addr));
        chk("hold_last",  64'(DumpLast),  64'(h_last));
      end
      held = 1'b0;
      if (DumpValid) begin
        h_data = DumpData; h_addr = DumpAddr; h_last = DumpLast;
        if (v.rnd) DumpReady = 1'($urandom_range(0, 1));
        else if (left > 0) begin
          DumpReady = 1'b0;
          left--;
        end else DumpReady = 1'b1;
        if (DumpReady) begin
          if (beat < 31) begin
            e_addr = 5'(beat);
            e_data = mem[beat];
`ifdef REGDUMP_CHECKSUM_EN
            e_last = 1'b0;
`else
            e_last = (beat == 30);
`endif
            csum ^= mem[beat];
          end else begin
            e_addr = 5'd31;
            e_data = csum;
            e_last = 1'b1;
          end
          chk("beat_addr", 64'(DumpAddr), 64'(e_addr));
          chk("beat_data", DumpData,      e_data);
          chk("beat_last", 64'(DumpLast), 64'(e_last));
          beat++;
          left = v.stalls;
        end else begin
          nstall++;
          held = 1'b1;
        end
      end
      if (v.hold_start) Start = 1'b1;
      else Start = (v.start_beat == beat) && DumpValid;
      @(posedge Clk); #1;
      cyc++;
    end
    if (!v.hold_start) Start = 1'b0;
    DumpReady = 1'b0;
    exp_c = v.rnd ? 62 + nstall : v.exp_cycles;
`ifdef REGDUMP_CHECKSUM_EN
    exp_c += v.rnd ? 1 : 1 + v.stalls;
`endif
    chk("done_seen", 64'(Done), 64'd1);
    chk("done_cycle", 64'(cyc), 64'(exp_c));
    chk("beat_count", 64'(beat), 64'(NB));
    chk("valid_at_done", 64'(DumpValid), 64'd0);
    @(posedge Clk); #1;
    chk("idle_busy", 64'(Busy), 64'd0);
    chk("idle_done", 64'(Done), 64'd0);
    chk("idle_ra_hold", 64'(RA), 64'd30);
    if (v.hold_start) begin
      @(posedge Clk); #1;
      chk("restart_busy", 64'(Busy), 64'd1);
      chk("restart_ra", 64'(RA), 64'd0);
      Start = 1'b0;
      do_reset("abort2");
    end
  endtask

  initial begin
    vec_t vecs [7];
    int   n;
    vecs[0] = '{64'h0101_0101_0000_0000, 1'b0, 0, 1'b0, -1, 1'b0, 62};
    vecs[1] = '{64'h0101_0101_0000_0000, 1'b0, 1, 1'b0, -1, 1'b0, 93};
    vecs[2] = '{64'hDEAD_BEEF_0000_0100, 1'b0, 2, 1'b0, -1, 1'b0, 124};
    vecs[3] = '{64'h0101_0101_0000_0000, 1'b0, 0, 1'b1, -1, 1'b0, -1};
    vecs[4] = '{64'h0101_0101_0000_0000, 1'b0, 0, 1'b0,  5, 1'b0, 62};
    vecs[5] = '{64'h0000_0000_0000_0000, 1'b0, 0, 1'b0, -1, 1'b1, 62};
    vecs[6] = '{64'h0000_0000_0000_0000, 1'b1, 0, 1'b0, -1, 1'b0, 62};

    ResetN = 1'b1;
    Start = 1'b0;
    DumpReady = 1'b0;
    preload(64'd0, 1'b0);
    #3 ResetN = 1'b0;
    #1 chk_reset_outputs("por");
    @(posedge Clk); #1;
    ResetN = 1'b1;
    @(posedge Clk); #1;
    chk_reset_outputs("post_release");

    foreach (vecs[k]) begin
      preload(vecs[k].base, vecs[k].x0_one);
      run_dump(vecs[k]);
    end

    // Reset while beat 12 is on the bus, then restart from index 0
    preload(64'h0101_0101_0000_0000, 1'b0);
    Start = 1'b1;
    DumpReady = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    n = 0;
    while (!(DumpValid && DumpAddr == 5'd12) && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    chk("reached_idx12", 64'(DumpValid && DumpAddr == 5'd12), 64'd1);
    do_reset("middump");
    run_dump(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
